fsm_ring: RTL and testbench

FSM_RING -- requirements
Module: fsm_ring

---
 rtl/fsm_ring.sv | 157 +++++++++++++++
 tb/tb_fsm_ring.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_ring.sv
// fsm_ring: a ring of N_STATES programmable state codes. The machine steps
// forward or backward from the highest-indexed state whose code matches y and
// whose go bit is set. It recovers to code 0 when y matches no code.
// Optional feature macro: FSM_RING_STATS_EN adds a saturating wrap counter
// on port wrap_count.
module fsm_ring #(
  parameter int N_STATES = 9,
  parameter int W        = 4,
  parameter int CNT_W    = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          dir,
  input  logic [N_STATES-1:0]           go,
  input  logic [N_STATES*W-1:0]         codes,
  output logic [W-1:0]                  y,
  output logic [$clog2(N_STATES)-1:0]   idx,
  output logic                          illegal,
  output logic                          step,
`ifdef FSM_RING_STATS_EN
  output logic                          wrap,
  output logic [CNT_W-1:0]              wrap_count
`else
  output logic                          wrap
`endif
);

  localparam int IDX_W = $clog2(N_STATES);

  logic [W-1:0]     y_q, y_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             init_q, init_d;

  logic [W-1:0]     code_arr [N_STATES];
  logic             any_match;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] tgt_idx;
  logic             tgt_wrap;

  // Unpack codes, detect any match and pick the highest matching index with go set.
  always_comb begin
    any_match = 1'b0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N_STATES; k++) begin
      code_arr[k] = codes[k*W +: W];
      if (y_q == code_arr[k]) begin
        any_match = 1'b1;
        if (go[k]) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(k);
        end
      end
    end
  end

  // Neighbour of the selected state in the requested direction, flagging the seam.
  always_comb begin
    tgt_idx  = '0;
    tgt_wrap = 1'b0;
    if (!dir) begin
      if (sel_idx == IDX_W'(N_STATES - 1)) begin
        tgt_idx  = '0;
        tgt_wrap = 1'b1;
      end else begin
        tgt_idx = sel_idx + IDX_W'(1);
      end
    end else begin
      if (sel_idx == '0) begin
        tgt_idx  = IDX_W'(N_STATES - 1);
        tgt_wrap = 1'b1;
      end else begin
        tgt_idx = sel_idx - IDX_W'(1);
      end
    end
  end

  // Illegal only once the init phase is over; codes changes show up without an edge.
  assign illegal = ~init_q & ~any_match;

  // Next-state logic: init load, step, recovery, or hold.
  always_comb begin
    y_d    = y_q;
    idx_d  = idx_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    init_d = init_q;
    if (init_q) begin
      y_d    = code_arr[0];
      idx_d  = '0;
      init_d = 1'b0;
    end else if (en) begin
      if (illegal) begin
        y_d   = code_arr[0];
        idx_d = '0;
      end else if (sel_found) begin
        y_d    = code_arr[tgt_idx];
        idx_d  = tgt_idx;
        step_d = 1'b1;
        wrap_d = tgt_wrap;
      end
    end
  end

  // State register with asynchronous active-low reset re-entering the init phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_q    <= '0;
      idx_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      init_q <= 1'b1;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      init_q <= init_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign step = step_q;
  assign wrap = wrap_q;

`ifdef FSM_RING_STATS_EN
  logic [CNT_W-1:0] wrap_count_q, wrap_count_d;

  // Count seam crossings, sticking at all-ones.
  always_comb begin
    wrap_count_d = wrap_count_q;
    if (wrap_d && (wrap_count_q != {CNT_W{1'b1}})) begin
      wrap_count_d = wrap_count_q + CNT_W'(1);
    end
  end

  // Wrap counter register, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrap_count_q <= '0;
    end else begin
      wrap_count_q <= wrap_count_d;
    end
  end

  assign wrap_count = wrap_count_q;
`else
  logic [CNT_W-1:0] stats_unused;
  assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_fsm_ring.sv
// Directed bench for fsm_ring with N_STATES=4, W=4, CNT_W=2, codes {12,9,5,3}.
module tb_fsm_ring;

  logic        clock;
  logic        reset;
  logic        en;
  logic        dir;
  logic [3:0]  go;
  logic [15:0] codes;
  logic [3:0]  y;
  logic [1:0]  idx;
  logic        illegal;
  logic        step;
  logic        wrap;
`ifdef FSM_RING_STATS_EN
  logic [1:0]  wrap_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [15:0] CODES_DEF = {4'd12, 4'd9, 4'd5, 4'd3};

  fsm_ring #(.N_STATES(4), .W(4), .CNT_W(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .dir        (dir),
    .go         (go),
    .codes      (codes),
    .y          (y),
    .idx        (idx),
    .illegal    (illegal),
    .step       (step),
`ifdef FSM_RING_STATS_EN
    .wrap       (wrap),
    .wrap_count (wrap_count)
`else
    .wrap       (wrap)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; dir = 1'b0; go = 4'b0000; codes = CODES_DEF;
    #3 reset = 1'b0;
    tick(); tick();
    n_cmp++; if (y !== 4'd0)      begin n_bad++; $display("FAIL rst_y got %0d want 0", y); end
    n_cmp++; if (idx !== 2'd0)    begin n_bad++; $display("FAIL rst_idx got %0d want 0", idx); end
    n_cmp++; if (step !== 1'b0)   begin n_bad++; $display("FAIL rst_step got %b want 0", step); end
    n_cmp++; if (wrap !== 1'b0)   begin n_bad++; $display("FAIL rst_wrap got %b want 0", wrap); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL rst_illegal got %b want 0", illegal); end
    reset = 1'b1;
    #1;
    n_cmp++; if (y !== 4'd0)      begin n_bad++; $display("FAIL rel_y_pre got %0d want 0", y); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL rel_illegal_pre got %b want 0", illegal); end
    tick();
    n_cmp++; if (y !== 4'd3)      begin n_bad++; $display("FAIL init_y got %0d want 3", y); end
    n_cmp++; if (idx !== 2'd0)    begin n_bad++; $display("FAIL init_idx got %0d want 0", idx); end
    n_cmp++; if (step !== 1'b0)   begin n_bad++; $display("FAIL init_step got %b want 0", step); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL init_illegal got %b want 0", illegal); end
  endtask

  task automatic test_forward();
    logic [3:0] exp_y   [4] = '{4'd5, 4'd9, 4'd12, 4'd3};
    logic [1:0] exp_idx [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic       exp_wr  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    en = 1'b1; dir = 1'b0; go = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (y !== exp_y[i])     begin n_bad++; $display("FAIL fwd_y[%0d] got %0d want %0d", i, y, exp_y[i]); end
      n_cmp++; if (idx !== exp_idx[i]) begin n_bad++; $display("FAIL fwd_idx[%0d] got %0d want %0d", i, idx, exp_idx[i]); end
      n_cmp++; if (step !== 1'b1)      begin n_bad++; $display("FAIL fwd_step[%0d] got %b want 1", i, step); end
      n_cmp++; if (wrap !== exp_wr[i]) begin n_bad++; $display("FAIL fwd_wrap[%0d] got %b want %b", i, wrap, exp_wr[i]); end
    end
  endtask

  task automatic test_backward();
    en = 1'b1; dir = 1'b1; go = 4'b0001;
    tick();
    n_cmp++; if (y !== 4'd12)  begin n_bad++; $display("FAIL bwd_y got %0d want 12", y); end
    n_cmp++; if (idx !== 2'd3) begin n_bad++; $display("FAIL bwd_idx got %0d want 3", idx); end
    n_cmp++; if (wrap !== 1'b1) begin n_bad++; $display("FAIL bwd_wrap got %b want 1", wrap); end
    n_cmp++; if (step !== 1'b1) begin n_bad++; $display("FAIL bwd_step got %b want 1", step); end
    go = 4'b0000;
    tick();
    n_cmp++; if (y !== 4'd12)  begin n_bad++; $display("FAIL nogo_y got %0d want 12", y); end
    n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL nogo_step got %b want 0", step); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL nogo_wrap got %b want 0", wrap); end
    // Step back once more (12 -> 9), no seam crossing.
    go = 4'b1000;
    tick();
    n_cmp++; if (y !== 4'd9)   begin n_bad++; $display("FAIL bwd2_y got %0d want 9", y); end
    n_cmp++; if (idx !== 2'd2) begin n_bad++; $display("FAIL bwd2_idx got %0d want 2", idx); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL bwd2_wrap got %b want 0", wrap); end
  endtask

  task automatic test_illegal();
    en = 1'b0; go = 4'b1111; dir = 1'b0;
    codes = {4'd12, 4'd7, 4'd5, 4'd3};
    #1;
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL ill_comb got %b want 1", illegal); end
    tick();
    n_cmp++; if (y !== 4'd9)       begin n_bad++; $display("FAIL ill_hold_y got %0d want 9", y); end
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL ill_hold_flag got %b want 1", illegal); end
    n_cmp++; if (step !== 1'b0)    begin n_bad++; $display("FAIL ill_hold_step got %b want 0", step); end
    en = 1'b1;
    tick();
    n_cmp++; if (y !== 4'd3)       begin n_bad++; $display("FAIL rec_y got %0d want 3", y); end
    n_cmp++; if (idx !== 2'd0)     begin n_bad++; $display("FAIL rec_idx got %0d want 0", idx); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL rec_illegal got %b want 0", illegal); end
    n_cmp++; if (step !== 1'b0)    begin n_bad++; $display("FAIL rec_step got %b want 0", step); end
    n_cmp++; if (wrap !== 1'b0)    begin n_bad++; $display("FAIL rec_wrap got %b want 0", wrap); end
    codes = CODES_DEF;
  endtask

  task automatic test_duplicate();
    codes = {4'd12, 4'd5, 4'd5, 4'd3};
    en = 1'b1; dir = 1'b0; go = 4'b0001;
    tick();
    n_cmp++; if (y !== 4'd5)   begin n_bad++; $display("FAIL dup_pre_y got %0d want 5", y); end
    go = 4'b0110;
    tick();
    n_cmp++; if (y !== 4'd12)  begin n_bad++; $display("FAIL dup_y got %0d want 12", y); end
    n_cmp++; if (idx !== 2'd3) begin n_bad++; $display("FAIL dup_idx got %0d want 3", idx); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL dup_wrap got %b want 0", wrap); end
    codes = CODES_DEF;
  endtask

  task automatic test_hold_en0();
    en = 1'b0; dir = 1'b0; go = 4'b1111;
    tick(); tick();
    n_cmp++; if (y !== 4'd12)  begin n_bad++; $display("FAIL en0_y got %0d want 12", y); end
    n_cmp++; if (idx !== 2'd3) begin n_bad++; $display("FAIL en0_idx got %0d want 3", idx); end
    n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL en0_step got %b want 0", step); end
  endtask

  task automatic test_async_reset();
    en = 1'b1; dir = 1'b0; go = 4'b1111;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++; if (y !== 4'd0)   begin n_bad++; $display("FAIL areset_y got %0d want 0", y); end
    n_cmp++; if (idx !== 2'd0) begin n_bad++; $display("FAIL areset_idx got %0d want 0", idx); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL areset_illegal got %b want 0", illegal); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (y !== 4'd3)   begin n_bad++; $display("FAIL areset_init_y got %0d want 3", y); end
    n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL areset_init_step got %b want 0", step); end
    tick();
    n_cmp++; if (y !== 4'd5)   begin n_bad++; $display("FAIL areset_run_y got %0d want 5", y); end
  endtask

`ifdef FSM_RING_STATS_EN
  task automatic test_wrap_count();
    reset = 1'b0; en = 1'b0; #2;
    reset = 1'b1;
    tick();
    en = 1'b1; dir = 1'b0; go = 4'b1111;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (wrap_count !== 2'd1) begin n_bad++; $display("FAIL wc_lap1 got %0d want 1", wrap_count); end
    for (int i = 0; i < 16; i++) tick();
    n_cmp++; if (wrap_count !== 2'd3) begin n_bad++; $display("FAIL wc_sat got %0d want 3", wrap_count); end
    tick(); tick();
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++; if (wrap_count !== 2'd0) begin n_bad++; $display("FAIL wc_reset got %0d want 0", wrap_count); end
    n_cmp++; if (y !== 4'd0) begin n_bad++; $display("FAIL wc_reset_y got %0d want 0", y); end
    reset = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_backward();
    test_illegal();
    test_duplicate();
    test_hold_en0();
    test_async_reset();
`ifdef FSM_RING_STATS_EN
    test_wrap_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
